// File: rtl/javk_uart_tx.sv
// Bus-mapped 8N1 serial transmitter for the JAVK CPU: a data register feeds a small FIFO
// that drains LSB-first onto tx, with a read-only status register for software polling.
module javk_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addrbus,
  input  logic        rw,
  inout  wire  [7:0]  databus,
  output logic        tx
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [15:0]   bitcnt;
  logic [2:0]    bitidx;
  logic [7:0]    shreg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          wr_hit_q;
  logic          rd_stat_q;

  logic          wr_hit;
  logic          rd_stat;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic          empty;
  logic          busy;
  logic          bit_done;
  logic [7:0]    head;
  logic [7:0]    status;
  logic [7:0]    rd_data;
  logic          rd_en;

  assign wr_hit   = (addrbus == BASE_ADDR) && !rw;
  assign rd_stat  = (addrbus == STAT_ADDR) && rw;
  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign bit_done = (bitcnt == LAST_CNT);
  assign head     = mem[rptr];

  // The CPU has no write strobe, so a push is the first cycle of a write to the data register.
  assign push    = wr_hit && !wr_hit_q;
  assign pop     = !empty && ((state == IDLE) || (state == STOP && bit_done));
  assign push_ok = push && (!full || pop);

  assign status  = {4'b0000, overflow, busy, empty, full};
  assign rd_data = (addrbus == STAT_ADDR) ? status : 8'h00;
  assign rd_en   = rw && ((addrbus == BASE_ADDR) || (addrbus == STAT_ADDR));
  assign databus = rd_en ? rd_data : 8'bz;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= databus;
    end
  end

  // Overflow is sticky and only clears once a status read has finished, so that read still sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      wr_hit_q  <= 1'b0;
      rd_stat_q <= 1'b0;
    end else begin
      wr_hit_q  <= wr_hit;
      rd_stat_q <= rd_stat;
      if (push_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push_ok) begin
        count <= count - (AW+1)'(1);
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end else if (rd_stat_q && !rd_stat) begin
        overflow <= 1'b0;
      end
    end
  end

  // STOP pops straight into START when more data is waiting, giving gapless back-to-back frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tx     <= 1'b1;
      bitcnt <= '0;
      bitidx <= '0;
      shreg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state  <= START;
            tx     <= 1'b0;
            shreg  <= head;
            bitcnt <= '0;
          end
        end
        START: begin
          if (bit_done) begin
            state  <= DATA;
            tx     <= shreg[0];
            bitidx <= '0;
            bitcnt <= '0;
          end else begin
            bitcnt <= bitcnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bitcnt <= '0;
            if (bitidx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shreg  <= shreg >> 1;
              tx     <= shreg[1];
              bitidx <= bitidx + 3'd1;
            end
          end else begin
            bitcnt <= bitcnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            bitcnt <= '0;
            if (!empty) begin
              state <= START;
              tx    <= 1'b0;
              shreg <= head;
            end else begin
              state <= IDLE;
            end
          end else begin
            bitcnt <= bitcnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_javk_uart_tx.sv
// Randomized bench for javk_uart_tx: a frame-schedule model predicts tx every cycle and the
// status register on every read.
module tb_javk_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [15:0] BASE  = 16'hFF00;
  localparam logic [15:0] STAT  = 16'hFF01;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addrbus;
  logic        rw;
  logic [7:0]  drv;
  logic        drv_en;
  tri1  [7:0]  databus;
  logic        tx;

  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          fstart[$];
  logic [7:0]  fbyte[$];
  bit          ovf;
  bit          wrprev;
  bit          rdprev;
  bit          wr_now;
  bit          rd_now;
  bit          txcheck_on = 1'b0;

  assign databus = drv_en ? drv : 8'bz;

  always #5 clk = ~clk;

  javk_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addrbus(addrbus),
    .rw     (rw),
    .databus(databus),
    .tx     (tx)
  );

  task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h at cycle %0d", tag, act, exp, cyc);
  endtask

  // Bytes still waiting in the FIFO after edge e are those whose frame starts later.
  function automatic int pending(input int e);
    int n = 0;
    foreach (fstart[i]) if (fstart[i] > e) n++;
    return n;
  endfunction

  function automatic bit busyAt(input int e);
    foreach (fstart[i]) if (e >= fstart[i] && e < fstart[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic expTx(input int e);
    int b;
    foreach (fstart[i]) begin
      if (e >= fstart[i] && e < fstart[i] + FRAME) begin
        b = (e - fstart[i]) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return fbyte[i][b-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [7:0] modelStatus();
    int p = pending(cyc);
    return {4'b0000, ovf, busyAt(cyc), p == 0, p >= DEPTH};
  endfunction

  // Frame schedule: each accepted byte starts one clk after its push or when the previous frame ends.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fstart.delete();
      fbyte.delete();
      ovf    = 1'b0;
      wrprev = 1'b0;
      rdprev = 1'b0;
    end else begin
      int last;
      int st;
      cyc++;
      wr_now = (addrbus == BASE) && (rw == 1'b0);
      rd_now = (addrbus == STAT) && (rw == 1'b1);
      if (rdprev && !rd_now) ovf = 1'b0;
      if (wr_now && !wrprev) begin
        if (pending(cyc) >= DEPTH) begin
          ovf = 1'b1;
        end else begin
          last = (fstart.size() > 0) ? fstart[fstart.size()-1] + FRAME : 0;
          st   = (cyc + 1 > last) ? cyc + 1 : last;
          fstart.push_back(st);
          fbyte.push_back(drv);
        end
      end
      wrprev = wr_now;
      rdprev = rd_now;
    end
  end

  always @(negedge clk) begin
    if (txcheck_on) checkOutput("tx", {7'b0, tx}, {7'b0, expTx(cyc)});
  end

  task automatic idleBus();
    addrbus = 16'h1234;
    rw      = 1'b1;
    drv     = 8'h00;
    drv_en  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic rwv, input logic [7:0] d, input int hold);
    addrbus = a;
    rw      = rwv;
    drv     = d;
    drv_en  = !rwv;
    repeat (hold) @(negedge clk);
    idleBus();
    @(negedge clk);
  endtask

  task automatic readCheck(input logic [15:0] a, input logic [7:0] exp, input string tag);
    addrbus = a;
    rw      = 1'b1;
    drv_en  = 1'b0;
    #1;
    checkOutput(tag, databus, exp);
    @(negedge clk);
    idleBus();
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic [15:0] a;
    int          n0;
    int          target;
    int          guard;
    logic [7:0]  five [5];

    idleBus();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    txcheck_on = 1'b1;
    checkOutput("reset_tx", {7'b0, tx}, 8'h01);
    checkOutput("reset_status", databus, 8'hFF);
    rst = 1'b0;
    @(negedge clk);

    readCheck(STAT, 8'h02, "idle_status");
    readCheck(BASE, 8'h00, "read_data_reg");
    readCheck(16'h1234, 8'hFF, "read_other_hiz");

    $display("[TB] single write of A5 held 3 cycles");
    applyStimulus(BASE, 1'b0, 8'hA5, 3);
    waitCycles(10);
    readCheck(STAT, 8'h06, "stat_busy_empty");
    waitCycles(40);
    readCheck(STAT, 8'h02, "stat_after_a5");

    $display("[TB] five writes, then overflow");
    five = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (five[i]) applyStimulus(BASE, 1'b0, five[i], 1);
    readCheck(STAT, 8'h05, "stat_full");
    applyStimulus(BASE, 1'b0, 8'h66, 1);
    readCheck(STAT, 8'h0D, "stat_overflow");
    readCheck(STAT, 8'h05, "stat_ovf_cleared");
    waitCycles(210);
    readCheck(STAT, 8'h02, "stat_drained");

    $display("[TB] reset mid-frame");
    applyStimulus(BASE, 1'b0, 8'h00, 1);
    d = 8'($urandom);
    applyStimulus(BASE, 1'b0, d, 1);
    d = 8'($urandom);
    applyStimulus(BASE, 1'b0, d, 1);
    waitCycles(8);
    #2 rst = 1'b1;
    #1 checkOutput("tx_async_reset", {7'b0, tx}, 8'h01);
    waitCycles(2);
    rst = 1'b0;
    @(negedge clk);
    readCheck(STAT, 8'h02, "stat_after_reset");
    waitCycles(50);

    $display("[TB] writes to other addresses and data-register reads");
    applyStimulus(16'hFF02, 1'b0, 8'h00, 2);
    readCheck(BASE, 8'h00, "read_ff00_a");
    readCheck(BASE, 8'h00, "read_ff00_b");
    waitCycles(10);
    readCheck(STAT, 8'h02, "stat_no_push");

    $display("[TB] push on the STOP->START pop edge while full");
    n0 = fstart.size();
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      applyStimulus(BASE, 1'b0, d, 1);
    end
    target = fstart[n0+1];
    guard  = 0;
    while (cyc < target - 1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reach_pop_edge", 8'(target - 1 - cyc), 8'h00);
    d = 8'($urandom);
    applyStimulus(BASE, 1'b0, d, 1);
    readCheck(STAT, 8'h05, "stat_full_no_ovf");
    waitCycles(FRAME * 6);
    readCheck(STAT, 8'h02, "stat_after_pop_push");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          d = 8'($urandom);
          applyStimulus(BASE, 1'b0, d, int'($urandom_range(1, 3)));
        end
        2: readCheck(STAT, modelStatus(), "rand_status");
        3: begin
          a = 16'($urandom);
          if (a == BASE) a = 16'h0000;
          d = 8'($urandom);
          applyStimulus(a, 1'b0, d, 1);
        end
        4: readCheck(BASE, 8'h00, "rand_read_ff00");
        default: waitCycles(int'($urandom_range(1, 30)));
      endcase
    end
    waitCycles(FRAME * (DEPTH + 2));
    readCheck(STAT, modelStatus(), "final_status");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/javk_uart_tx.md
Name: javk_uart_tx

Overview:
- Memory-mapped serial transmitter peripheral on the JAVK CPU's 8-bit data bus and 16-bit address bus, downstream of the CPU.
- The CPU writes bytes to a data register. The block queues them in a small FIFO and shifts them out on a single 8N1 serial line, LSB first.
- A read-only status register lets software poll full, empty, busy and overflow.

Parameters:
- BASE_ADDR, 16'hFF00: address of the data register; the status register is at BASE_ADDR+1.
- CLKS_PER_BIT, 16: clk cycles per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4: FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- addrbus  input  16  CPU address bus.
- rw  input  1  1 = CPU read, 0 = CPU write.
- databus  inout  8  shared data bus.
- tx  output  1  serial line; idle high.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst high, including mid-frame):
  - tx=1, FIFO emptied, state IDLE, overflow=0, edge-detect registers cleared.
  - databus follows the combinational read rule below; it is not affected by reset.
- Bus read (combinational, no clock latency):
  - When rw=1 and addrbus==BASE_ADDR, the block drives databus=8'h00.
  - When rw=1 and addrbus==BASE_ADDR+1, it drives {4'b0, overflow, busy, empty, full}.
  - In all other cases databus is high-Z.
  - busy=1 whenever state!=IDLE.
- Write detection: the CPU has no strobe, so writes are edge-qualified.
  - wr_hit = (addrbus==BASE_ADDR && rw==0); a registered copy wr_hit_q is kept.
  - A push happens on the rising edge where wr_hit=1 and wr_hit_q=0. The value pushed is databus sampled at that edge.
  - A write held for N cycles pushes exactly once.
  - Dropping rw or changing the address, then returning to the data register, arms a new push.
- Status read-clear:
  - rd_stat = (addrbus==BASE_ADDR+1 && rw==1), registered as rd_stat_q.
  - overflow clears on the edge where rd_stat=0 and rd_stat_q=1, i.e. after the read completes, so the read itself still returns 1.
- FIFO:
  - Pointer-based, count 0..FIFO_DEPTH; full when count==FIFO_DEPTH, empty when count==0.
  - A push while full drops the byte and sets overflow (sticky).
  - If a push and a pop occur on the same edge while full, the push is accepted and count is unchanged.
  - A pop never occurs while empty.
- Transmit FSM states: IDLE, START, DATA, STOP. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) drive the timing.
  - IDLE -> START: on an edge with FIFO non-empty. At that edge the head is popped into the shift register, tx goes 0 and the bit counter clears.
  - START: after CLKS_PER_BIT cycles, go to DATA, tx=shift[0], bit index=0.
  - DATA: every CLKS_PER_BIT cycles, shift right and advance the bit index. After bit 7 has been held CLKS_PER_BIT cycles, go to STOP with tx=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go directly to START (back-to-back, no idle cycle); otherwise go to IDLE.
  - Each frame lasts exactly 10*CLKS_PER_BIT cycles from the tx falling edge.
  - Latency from the push edge into an empty, idle block to tx falling is 1 clk.
- Queue/shift rules: bytes are sent in write order. A byte already popped into the shift register is unaffected by later pushes or by overflow.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=16'hFF00):
- Reset hold, then idle:
  - tx=1; a read of FF01 returns 8'h02 (empty).
  - A read of FF00 returns 8'h00.
  - A read of any other address leaves databus=Z.
- Write 8'hA5 to FF00, held for 3 cycles:
  - Exactly one frame is sent.
  - tx=0 for 4 clks, then 1,0,1,0,0,1,0,1 (4 clks each), then 1 for 4 clks; 40 clks total.
  - A status read during the frame returns 8'h06 (busy, empty).
- Five separate writes 11,22,33,44,55 while idle:
  - The first byte pops into the shift register immediately; the remaining four fill the FIFO.
  - Status then reads 8'h05 (busy, full).
  - A sixth write of 8'h66 sets overflow: status reads 8'h0D. After that read completes, status reads 8'h05.
  - The serial output is 11,22,33,44,55 back-to-back, 200 clks total, with no idle gap; 66 is never sent.
- Assert rst mid-way through DATA with 2 bytes queued:
  - tx goes 1 asynchronously, before the next clk edge.
  - After release, status reads 8'h02 and no frame resumes.
- Write 8'h00 to address FF02, and perform reads with rw=1 at FF00:
  - No push occurs and no frame is started.
- Push on the same edge as the STOP->START pop while full:
  - The new byte is accepted (count stays 4, overflow stays 0).
  - All bytes are transmitted in order.
